front_dispatch_router: RTL and testbench
========================================

Name: front_dispatch_router

Overview:
Final front-end stage, directly upstream of u_backend. It takes the single in-order decoded instruction stream and the interconnect (icon) instruction stream from decode. It steers each instruction into a per-execution-unit FIFO that drives the backend dispatch bus, and distributes icon instructions round-robin over per-channel holding registers. All backend-facing valid/ready pairs originate here, which decouples decode from per-EU and per-channel stalls.

Parameters:
NUM_EXEC_UNITS, 4, number of EU dispatch ports; must match u_backend
NUM_ICON_CHANNELS, 4, number of icon dispatch ports; must match u_backend
EU_FIFO_DEPTH, 4, entries per EU FIFO; power of 2, >=2

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
flush_i  in  1  synchronous clear of all buffered state
instr_i  in  type_iqueue_entry  decoded instruction
instr_eu_idx_i  in  $clog2(NUM_EXEC_UNITS)+1  target EU index
instr_valid_i  in  1  instr_i valid
instr_ready_o  out  1  instr_i accepted this cycle if valid
icon_instr_i  in  type_icon_instr  decoded icon instruction
icon_instr_valid_i  in  1  icon_instr_i valid
icon_instr_ready_o  out  1  icon_instr_i accepted this cycle if valid
instr_dispatch_o  out  type_iqueue_entry [NUM_EXEC_UNITS]  per-EU FIFO head
instr_dispatch_valid_o  out  1 [NUM_EXEC_UNITS]  per-EU FIFO non-empty
instr_dispatch_ready_i  in  1 [NUM_EXEC_UNITS]  EU IQueue ready
icon_instr_dispatch_o  out  type_icon_instr [NUM_ICON_CHANNELS]  channel holding register
icon_instr_dispatch_valid_o  out  1 [NUM_ICON_CHANNELS]  holding register occupied
icon_instr_dispatch_ready_i  in  1 [NUM_ICON_CHANNELS]  icon controller ready
idle_o  out  1  all FIFOs and holding registers empty
illegal_idx_o  out  1  sticky: instr accepted with instr_eu_idx_i >= NUM_EXEC_UNITS

Behaviour:
- Reset (reset_n=0 at clk edge): all FIFO read/write pointers 0; all dispatch valids 0; icon round-robin pointer 0; illegal_idx_o 0; idle_o 1. Data outputs are don't-care while their valid is 0.
- instr_ready_o = !flush_i && (idx illegal || !full[instr_eu_idx_i]). It is combinational on the index only and does not depend on instr_valid_i.
- Push to FIFO[idx] on instr_valid_i && instr_ready_o. An illegal idx is accepted, dropped, and sets illegal_idx_o; it stays set until reset.
- Pop FIFO[e] on instr_dispatch_valid_o[e] && instr_dispatch_ready_i[e].
- Per-EU FIFO: pointers are $clog2(EU_FIFO_DEPTH)+1 bits wide and wrap naturally. Full when the MSBs differ and the rest are equal; empty when the pointers are equal.
- No bypass: an accepted instruction appears at instr_dispatch_o no earlier than the next cycle (min latency 1).
- Full blocks a push even when a pop happens in the same cycle. Push and pop in the same cycle on a non-full, non-empty FIFO keeps the count unchanged.
- Order is preserved per EU. There is no ordering guarantee across EUs.
- instr_dispatch_valid_o[e] = !empty[e]. instr_dispatch_o[e] is the head entry and stays stable while valid && !ready.
- Icon path: each channel has a 1-entry holding register with an occupied bit.
  - Selection: the first unoccupied channel searching from rr_ptr upward, wrapping modulo NUM_ICON_CHANNELS.
  - icon_instr_ready_o = !flush_i && any channel unoccupied. Occupancy is taken from registered state, so a channel draining this cycle is not refillable until the next cycle.
  - On accept: load the selected channel, set occupied, rr_ptr <= selected+1 (wrap).
  - On icon_instr_dispatch_valid_o[c] && icon_instr_dispatch_ready_i[c]: clear occupied[c].
- flush_i=1: next edge clears all FIFO pointers, occupied bits and rr_ptr. No accepts during the flush cycle. Pending outputs drop without a handshake. illegal_idx_o is not cleared by flush. Reset has priority over flush.
- idle_o = all FIFOs empty && no channel occupied (registered-state based).

Optional Feature:
DISPATCH_PERF_CNT_EN
- Defined: adds output stall_cycles_o (32 bits, saturating) and output eu_full_cycles_o [NUM_EXEC_UNITS] (32 bits each, saturating).
  - stall_cycles_o counts cycles with (instr_valid_i && !instr_ready_o) || (icon_instr_valid_i && !icon_instr_ready_o).
  - eu_full_cycles_o[e] counts cycles with FIFO[e] full.
  - Both are zeroed by reset and not by flush.
- Undefined: these ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
1. Reset, then one instr to idx 2 at cycle 0 -> instr_dispatch_valid_o[2]=1 at cycle 1 with identical payload; other valids 0; idle_o 0 until popped.
2. With instr_dispatch_ready_i[1]=0, push 5 instrs A..E to idx 1 (depth 4) -> A..D accepted, instr_ready_o=0 on E. Raise ready -> A,B,C,D popped in order; E accepted the cycle after the first pop.
3. FIFO[0] full and popping in the same cycle as a valid push to idx 0 -> push rejected. Interleaved pushes to idx 0/3 with both ready -> each EU sees its own in-order subsequence.
4. All icon readies 0, issue 5 icon instrs -> they land in channels 0,1,2,3, the 5th stalls. Raise ready[2] for one cycle -> channel 2 clears, the 5th loads into channel 2 the following cycle; rr_ptr then 3.
5. instr_eu_idx_i=4 (NUM_EXEC_UNITS=4) valid -> accepted, no FIFO changes, illegal_idx_o=1 and stays 1 through a flush.
6. Fill FIFO[1] with 3 entries and occupy 2 channels, then pulse flush_i with valid inputs -> inputs not accepted; next cycle all valids 0, idle_o=1, rr_ptr=0.

Source files
------------

// File: rtl/front_dispatch_router.sv
// Front-end dispatch: per-EU instruction FIFOs plus round-robin icon holding registers feeding u_backend.
// Optional build macro DISPATCH_PERF_CNT_EN adds saturating stall and EU-full cycle counters.
package front_dispatch_pkg;
    typedef logic [31:0] type_iqueue_entry;
    typedef logic [15:0] type_icon_instr;
endpackage

module front_dispatch_router
    import front_dispatch_pkg::*;
#(
    parameter int NUM_EXEC_UNITS    = 4,
    parameter int NUM_ICON_CHANNELS = 4,
    parameter int EU_FIFO_DEPTH     = 4
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                flush_i,
    input  type_iqueue_entry                    instr_i,
    input  logic [$clog2(NUM_EXEC_UNITS):0]     instr_eu_idx_i,
    input  logic                                instr_valid_i,
    output logic                                instr_ready_o,
    input  type_icon_instr                      icon_instr_i,
    input  logic                                icon_instr_valid_i,
    output logic                                icon_instr_ready_o,
    output type_iqueue_entry                    instr_dispatch_o [NUM_EXEC_UNITS],
    output logic [NUM_EXEC_UNITS-1:0]           instr_dispatch_valid_o,
    input  logic [NUM_EXEC_UNITS-1:0]           instr_dispatch_ready_i,
    output type_icon_instr                      icon_instr_dispatch_o [NUM_ICON_CHANNELS],
    output logic [NUM_ICON_CHANNELS-1:0]        icon_instr_dispatch_valid_o,
    input  logic [NUM_ICON_CHANNELS-1:0]        icon_instr_dispatch_ready_i,
    output logic                                idle_o,
    output logic                                illegal_idx_o
`ifdef DISPATCH_PERF_CNT_EN
    ,
    output logic [31:0]                         stall_cycles_o,
    output logic [31:0]                         eu_full_cycles_o [NUM_EXEC_UNITS]
`endif
);

    localparam int AW   = $clog2(EU_FIFO_DEPTH);
    localparam int PW   = AW + 1;
    localparam int CH_W = (NUM_ICON_CHANNELS > 1) ? $clog2(NUM_ICON_CHANNELS) : 1;

    logic [PW-1:0]            wr_ptr [NUM_EXEC_UNITS];
    logic [PW-1:0]            rd_ptr [NUM_EXEC_UNITS];
    type_iqueue_entry         fifo_mem [NUM_EXEC_UNITS][EU_FIFO_DEPTH];
    logic [NUM_EXEC_UNITS-1:0] fifo_full;
    logic [NUM_EXEC_UNITS-1:0] fifo_empty;
    logic [NUM_EXEC_UNITS-1:0] fifo_push;
    logic [NUM_EXEC_UNITS-1:0] fifo_pop;
    logic                     idx_illegal;
    logic                     sel_full;
    logic                     instr_accept;

    logic [NUM_ICON_CHANNELS-1:0] occupied;
    type_icon_instr               hold_reg [NUM_ICON_CHANNELS];
    logic [CH_W-1:0]              rr_ptr;
    logic [CH_W-1:0]              sel_ch;
    logic [CH_W-1:0]              rr_next;
    logic                         sel_found;
    logic                         icon_accept;
    logic [NUM_ICON_CHANNELS-1:0] icon_load;
    logic [NUM_ICON_CHANNELS-1:0] icon_pop;
    int                           cand;

    // Full/empty use the extra pointer MSB so all DEPTH slots are usable.
    always_comb begin
        fifo_full  = '0;
        fifo_empty = '0;
        for (int e = 0; e < NUM_EXEC_UNITS; e++) begin
            fifo_empty[e] = (wr_ptr[e] == rd_ptr[e]);
            fifo_full[e]  = (wr_ptr[e][PW-1] != rd_ptr[e][PW-1]) &&
                            (wr_ptr[e][AW-1:0] == rd_ptr[e][AW-1:0]);
        end
    end

    always_comb begin
        idx_illegal = (int'(instr_eu_idx_i) >= NUM_EXEC_UNITS);
        sel_full    = 1'b0;
        for (int e = 0; e < NUM_EXEC_UNITS; e++) begin
            if (int'(instr_eu_idx_i) == e) begin
                sel_full = fifo_full[e];
            end
        end
        instr_ready_o = !flush_i && (idx_illegal || !sel_full);
        instr_accept  = instr_valid_i && instr_ready_o;
        fifo_push     = '0;
        fifo_pop      = '0;
        for (int e = 0; e < NUM_EXEC_UNITS; e++) begin
            fifo_push[e] = instr_accept && !idx_illegal && (int'(instr_eu_idx_i) == e);
            fifo_pop[e]  = !fifo_empty[e] && instr_dispatch_ready_i[e];
        end
    end

    always_ff @(posedge clk) begin
        for (int e = 0; e < NUM_EXEC_UNITS; e++) begin
            if (fifo_push[e]) begin
                fifo_mem[e][wr_ptr[e][AW-1:0]] <= instr_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int e = 0; e < NUM_EXEC_UNITS; e++) begin
                wr_ptr[e] <= '0;
                rd_ptr[e] <= '0;
            end
            illegal_idx_o <= 1'b0;
        end else begin
            for (int e = 0; e < NUM_EXEC_UNITS; e++) begin
                if (flush_i) begin
                    wr_ptr[e] <= '0;
                    rd_ptr[e] <= '0;
                end else begin
                    if (fifo_push[e]) wr_ptr[e] <= wr_ptr[e] + PW'(1);
                    if (fifo_pop[e])  rd_ptr[e] <= rd_ptr[e] + PW'(1);
                end
            end
            if (instr_accept && idx_illegal) begin
                illegal_idx_o <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int e = 0; e < NUM_EXEC_UNITS; e++) begin
            instr_dispatch_o[e] = fifo_mem[e][rd_ptr[e][AW-1:0]];
        end
        instr_dispatch_valid_o = ~fifo_empty;
    end

    // Round-robin search for the first free channel at or above rr_ptr.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        cand      = 0;
        for (int k = 0; k < NUM_ICON_CHANNELS; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_ICON_CHANNELS) cand = cand - NUM_ICON_CHANNELS;
            if (!sel_found && !occupied[cand]) begin
                sel_found = 1'b1;
                sel_ch    = CH_W'(cand);
            end
        end
        rr_next            = (int'(sel_ch) == NUM_ICON_CHANNELS - 1) ? '0 : sel_ch + CH_W'(1);
        icon_instr_ready_o = !flush_i && sel_found;
        icon_accept        = icon_instr_valid_i && icon_instr_ready_o;
        icon_load          = '0;
        icon_pop           = '0;
        for (int c = 0; c < NUM_ICON_CHANNELS; c++) begin
            icon_load[c] = icon_accept && (int'(sel_ch) == c);
            icon_pop[c]  = occupied[c] && icon_instr_dispatch_ready_i[c];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            occupied <= '0;
            rr_ptr   <= '0;
        end else if (flush_i) begin
            occupied <= '0;
            rr_ptr   <= '0;
        end else begin
            occupied <= (occupied & ~icon_pop) | icon_load;
            if (icon_accept) rr_ptr <= rr_next;
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_ICON_CHANNELS; c++) begin
            if (icon_load[c]) hold_reg[c] <= icon_instr_i;
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_ICON_CHANNELS; c++) begin
            icon_instr_dispatch_o[c] = hold_reg[c];
        end
        icon_instr_dispatch_valid_o = occupied;
        idle_o = (&fifo_empty) && !(|occupied);
    end

`ifdef DISPATCH_PERF_CNT_EN
    logic stall_now;
    assign stall_now = (instr_valid_i && !instr_ready_o) || (icon_instr_valid_i && !icon_instr_ready_o);

    // Counters hold at all-ones and survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cycles_o <= '0;
            for (int e = 0; e < NUM_EXEC_UNITS; e++) eu_full_cycles_o[e] <= '0;
        end else begin
            if (stall_now && (stall_cycles_o != '1)) stall_cycles_o <= stall_cycles_o + 32'd1;
            for (int e = 0; e < NUM_EXEC_UNITS; e++) begin
                if (fifo_full[e] && (eu_full_cycles_o[e] != '1)) begin
                    eu_full_cycles_o[e] <= eu_full_cycles_o[e] + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_front_dispatch_router.sv
// Randomized scoreboard bench for front_dispatch_router: a queue-based model predicts accepts,
// per-EU ordering, icon channel placement, idle and the sticky illegal-index flag.
module tb_front_dispatch_router;
    import front_dispatch_pkg::*;

    localparam int NEU   = 4;
    localparam int NCH   = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n;
    logic             flush_i;
    type_iqueue_entry instr_i;
    logic [2:0]       instr_eu_idx_i;
    logic             instr_valid_i;
    logic             instr_ready_o;
    type_icon_instr   icon_instr_i;
    logic             icon_instr_valid_i;
    logic             icon_instr_ready_o;
    type_iqueue_entry instr_dispatch_o [NEU];
    logic [NEU-1:0]   instr_dispatch_valid_o;
    logic [NEU-1:0]   instr_dispatch_ready_i;
    type_icon_instr   icon_instr_dispatch_o [NCH];
    logic [NCH-1:0]   icon_instr_dispatch_valid_o;
    logic [NCH-1:0]   icon_instr_dispatch_ready_i;
    logic             idle_o;
    logic             illegal_idx_o;

    front_dispatch_router #(
        .NUM_EXEC_UNITS(NEU), .NUM_ICON_CHANNELS(NCH), .EU_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush_i(flush_i),
        .instr_i(instr_i), .instr_eu_idx_i(instr_eu_idx_i),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .icon_instr_i(icon_instr_i), .icon_instr_valid_i(icon_instr_valid_i),
        .icon_instr_ready_o(icon_instr_ready_o),
        .instr_dispatch_o(instr_dispatch_o), .instr_dispatch_valid_o(instr_dispatch_valid_o),
        .instr_dispatch_ready_i(instr_dispatch_ready_i),
        .icon_instr_dispatch_o(icon_instr_dispatch_o),
        .icon_instr_dispatch_valid_o(icon_instr_dispatch_valid_o),
        .icon_instr_dispatch_ready_i(icon_instr_dispatch_ready_i),
        .idle_o(idle_o), .illegal_idx_o(illegal_idx_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: what each EU still owes, and what each icon channel holds.
    type_iqueue_entry exp_q [NEU][$];
    int               fresh_eu [NEU];
    bit               ch_occ [NCH];
    bit               ch_fresh [NCH];
    type_icon_instr   ch_val [NCH];
    int               rr_model;
    bit               illegal_reg;
    bit               illegal_next;
    bit               mon_en = 1'b0;

    int valid_pct, illegal_pct, ready_pct, icon_ready_pct, flush_pct;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus();
        flush_i        = ($urandom_range(99) < flush_pct);
        instr_valid_i  = ($urandom_range(99) < valid_pct);
        instr_i        = $urandom;
        if ($urandom_range(99) < illegal_pct) instr_eu_idx_i = 3'(4 + $urandom_range(3));
        else                                  instr_eu_idx_i = 3'($urandom_range(NEU - 1));
        icon_instr_valid_i = ($urandom_range(99) < valid_pct);
        icon_instr_i       = 16'($urandom);
        for (int e = 0; e < NEU; e++) instr_dispatch_ready_i[e] = ($urandom_range(99) < ready_pct);
        for (int c = 0; c < NCH; c++) icon_instr_dispatch_ready_i[c] = ($urandom_range(99) < icon_ready_pct);
    endtask

    // Predict handshakes from the model's registered view and record accepted items.
    task automatic predictAccept();
        bit exp_rdy;
        bit any_free;
        int sel;
        int cc;
        int idx;
        idx     = int'(instr_eu_idx_i);
        exp_rdy = !flush_i && ((idx >= NEU) || (exp_q[idx].size() < DEPTH));
        checkOutput("instr_ready", 64'(instr_ready_o), 64'(exp_rdy));
        if (instr_valid_i && exp_rdy) begin
            if (idx >= NEU) illegal_next = 1'b1;
            else begin
                exp_q[idx].push_back(instr_i);
                fresh_eu[idx]++;
            end
        end
        any_free = 1'b0;
        sel      = -1;
        for (int k = 0; k < NCH; k++) begin
            cc = (rr_model + k) % NCH;
            if (!ch_occ[cc]) begin
                any_free = 1'b1;
                if (sel < 0) sel = cc;
            end
        end
        exp_rdy = !flush_i && any_free;
        checkOutput("icon_ready", 64'(icon_instr_ready_o), 64'(exp_rdy));
        if (icon_instr_valid_i && exp_rdy) begin
            ch_occ[sel]   = 1'b1;
            ch_fresh[sel] = 1'b1;
            ch_val[sel]   = icon_instr_i;
            rr_model      = (sel + 1) % NCH;
        end
    endtask

    // Monitor: runs late in each cycle, after stimulus has settled and been recorded.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (mon_en) begin
                bit exp_idle;
                bit exp_v;
                exp_idle = 1'b1;
                for (int e = 0; e < NEU; e++) if (exp_q[e].size() - fresh_eu[e] > 0) exp_idle = 1'b0;
                for (int c = 0; c < NCH; c++) if (ch_occ[c] && !ch_fresh[c]) exp_idle = 1'b0;
                checkOutput("idle", 64'(idle_o), 64'(exp_idle));
                checkOutput("illegal_idx", 64'(illegal_idx_o), 64'(illegal_reg));
                illegal_reg = illegal_next;
                for (int e = 0; e < NEU; e++) begin
                    exp_v = (exp_q[e].size() - fresh_eu[e] > 0);
                    checkOutput($sformatf("eu%0d_valid", e), 64'(instr_dispatch_valid_o[e]), 64'(exp_v));
                    if (exp_v) begin
                        checkOutput($sformatf("eu%0d_data", e), 64'(instr_dispatch_o[e]), 64'(exp_q[e][0]));
                        if (instr_dispatch_ready_i[e]) void'(exp_q[e].pop_front());
                    end
                end
                for (int c = 0; c < NCH; c++) begin
                    exp_v = ch_occ[c] && !ch_fresh[c];
                    checkOutput($sformatf("ch%0d_valid", c), 64'(icon_instr_dispatch_valid_o[c]), 64'(exp_v));
                    if (exp_v) begin
                        checkOutput($sformatf("ch%0d_data", c), 64'(icon_instr_dispatch_o[c]), 64'(ch_val[c]));
                        if (icon_instr_dispatch_ready_i[c]) ch_occ[c] = 1'b0;
                    end
                end
                if (flush_i) begin
                    for (int e = 0; e < NEU; e++) exp_q[e].delete();
                    for (int c = 0; c < NCH; c++) ch_occ[c] = 1'b0;
                    rr_model = 0;
                end
                for (int e = 0; e < NEU; e++) fresh_eu[e] = 0;
                for (int c = 0; c < NCH; c++) ch_fresh[c] = 1'b0;
            end
        end
    end

    task automatic runPhase(input int vp, input int ip, input int rp, input int irp, input int fp, input int cycles);
        valid_pct = vp; illegal_pct = ip; ready_pct = rp; icon_ready_pct = irp; flush_pct = fp;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            applyStimulus();
            #1;
            predictAccept();
        end
    endtask

    initial begin
        reset_n = 1'b0; flush_i = 1'b0; instr_i = '0; instr_eu_idx_i = '0; instr_valid_i = 1'b0;
        icon_instr_i = '0; icon_instr_valid_i = 1'b0;
        instr_dispatch_ready_i = '0; icon_instr_dispatch_ready_i = '0;
        rr_model = 0; illegal_reg = 1'b0; illegal_next = 1'b0;
        for (int e = 0; e < NEU; e++) fresh_eu[e] = 0;
        for (int c = 0; c < NCH; c++) begin ch_occ[c] = 1'b0; ch_fresh[c] = 1'b0; ch_val[c] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_idle", 64'(idle_o), 64'd1);
        checkOutput("reset_eu_valid", 64'(instr_dispatch_valid_o), 64'd0);
        checkOutput("reset_ch_valid", 64'(icon_instr_dispatch_valid_o), 64'd0);
        checkOutput("reset_illegal", 64'(illegal_idx_o), 64'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        runPhase(70, 6, 60, 50, 2, 600);
        runPhase(90, 0, 0, 0, 0, 40);
        runPhase(90, 0, 50, 30, 0, 300);
        runPhase(80, 10, 40, 40, 10, 300);
        runPhase(90, 0, 0, 0, 0, 30);
        runPhase(0, 0, 100, 100, 0, 30);
        @(negedge clk);
        for (int e = 0; e < NEU; e++) checkOutput($sformatf("drain_eu%0d", e), 64'(exp_q[e].size()), 64'd0);
        checkOutput("drain_idle", 64'(idle_o), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
